// File: rtl/amci_pkg.sv
// Shared opcodes and FSM state encoding for the AMCI command sequencer.
package amci_pkg;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_RMW   = 2'd2;
  localparam logic [1:0] OP_POLL  = 2'd3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    WR_ISSUE = 3'd3,
    WR_WAIT  = 3'd4,
    RESP     = 3'd5
  } state_t;

  // Poll timer width: enough bits to hold the limit itself, never zero.
  function automatic int tmr_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/amci_cmd_sequencer.sv
// Single-command engine in front of the AXI4-Lite master: turns WRITE/READ/RMW/POLL
// commands into AMCI read/write pulses and returns one response per command.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | waiting for a command (ready unless a response is pending)
//   RD_ISSUE | waiting for the read side to go idle, then pulse AMCI_READ
//   RD_WAIT  | waiting for read data; READ/RMW/POLL branch from here
//   WR_ISSUE | waiting for the write side to go idle, then pulse AMCI_WRITE
//   WR_WAIT  | waiting for the write to finish
//   RESP     | response presented until RSP_READY
module amci_cmd_sequencer
  import amci_pkg::*;
#(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int POLL_TIMEOUT     = 1000000
) (
  input  logic                        M_AXI_ACLK,
  input  logic                        M_AXI_ARESETN,
  input  logic                        CMD_VALID,
  output logic                        CMD_READY,
  input  logic [1:0]                  CMD_OP,
  input  logic [C_AXI_ADDR_WIDTH-1:0] CMD_ADDR,
  input  logic [C_AXI_DATA_WIDTH-1:0] CMD_DATA,
  input  logic [C_AXI_DATA_WIDTH-1:0] CMD_MASK,
  output logic                        RSP_VALID,
  input  logic                        RSP_READY,
  output logic [C_AXI_DATA_WIDTH-1:0] RSP_DATA,
  output logic                        RSP_TIMEOUT,
  output logic [C_AXI_ADDR_WIDTH-1:0] AMCI_WADDR,
  output logic [C_AXI_DATA_WIDTH-1:0] AMCI_WDATA,
  output logic                        AMCI_WRITE,
  input  logic                        AMCI_WIDLE,
  output logic [C_AXI_ADDR_WIDTH-1:0] AMCI_RADDR,
  output logic                        AMCI_READ,
  input  logic [C_AXI_DATA_WIDTH-1:0] AMCI_RDATA,
  input  logic                        AMCI_RIDLE
);

  localparam int              TW      = tmr_width(POLL_TIMEOUT);
  localparam logic [TW-1:0]   TMR_MAX = TW'(POLL_TIMEOUT);

  state_t                      state, state_nxt;
  logic [1:0]                  op_q, op_nxt;
  logic [C_AXI_DATA_WIDTH-1:0] data_q, data_nxt;
  logic [C_AXI_DATA_WIDTH-1:0] mask_q, mask_nxt;
  logic [TW-1:0]               tmr, tmr_nxt;
  logic                        run_q;
  logic                        rsp_valid_nxt, rsp_timeout_nxt, write_nxt, read_nxt;
  logic [C_AXI_DATA_WIDTH-1:0] rsp_data_nxt, wdata_nxt;
  logic [C_AXI_ADDR_WIDTH-1:0] waddr_nxt, raddr_nxt;
  logic                        expired, rd_done, wr_done, poll_hit;
  logic [C_AXI_DATA_WIDTH-1:0] merged;

  // run_q keeps CMD_READY low while reset is applied, using registers only.
  assign CMD_READY = run_q & (state == IDLE) & ~RSP_VALID;
  assign expired   = (POLL_TIMEOUT != 0) && (tmr == TMR_MAX);
  assign rd_done   = ~AMCI_READ & AMCI_RIDLE;
  assign wr_done   = ~AMCI_WRITE & AMCI_WIDLE;
  assign poll_hit  = ((AMCI_RDATA & mask_q) == (data_q & mask_q));
  assign merged    = (AMCI_RDATA & ~mask_q) | (data_q & mask_q);

  always_comb begin
    state_nxt       = state;
    op_nxt          = op_q;
    data_nxt        = data_q;
    mask_nxt        = mask_q;
    tmr_nxt         = tmr;
    rsp_valid_nxt   = RSP_VALID;
    rsp_timeout_nxt = RSP_TIMEOUT;
    rsp_data_nxt    = RSP_DATA;
    wdata_nxt       = AMCI_WDATA;
    waddr_nxt       = AMCI_WADDR;
    raddr_nxt       = AMCI_RADDR;
    write_nxt       = 1'b0;
    read_nxt        = 1'b0;

    if (state != IDLE && op_q == OP_POLL && tmr != TMR_MAX) tmr_nxt = tmr + TW'(1);

    case (state)
      IDLE: begin
        if (CMD_VALID && CMD_READY) begin
          op_nxt    = CMD_OP;
          data_nxt  = CMD_DATA;
          mask_nxt  = CMD_MASK;
          waddr_nxt = CMD_ADDR;
          raddr_nxt = CMD_ADDR;
          state_nxt = (CMD_OP == OP_WRITE) ? WR_ISSUE : RD_ISSUE;
          if (CMD_OP == OP_POLL) tmr_nxt = '0;
        end
      end
      RD_ISSUE: begin
        if (AMCI_RIDLE) begin
          read_nxt  = 1'b1;
          state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (rd_done) begin
          case (op_q)
            OP_RMW: begin
              wdata_nxt    = merged;
              rsp_data_nxt = AMCI_RDATA;
              state_nxt    = WR_ISSUE;
            end
            OP_POLL: begin
              if (poll_hit || expired) begin
                rsp_data_nxt    = AMCI_RDATA;
                rsp_timeout_nxt = ~poll_hit;
                rsp_valid_nxt   = 1'b1;
                state_nxt       = RESP;
              end else begin
                state_nxt = RD_ISSUE;
              end
            end
            default: begin
              rsp_data_nxt    = AMCI_RDATA;
              rsp_timeout_nxt = 1'b0;
              rsp_valid_nxt   = 1'b1;
              state_nxt       = RESP;
            end
          endcase
        end
      end
      WR_ISSUE: begin
        if (AMCI_WIDLE) begin
          write_nxt = 1'b1;
          state_nxt = WR_WAIT;
          if (op_q == OP_WRITE) begin
            wdata_nxt    = data_q;
            rsp_data_nxt = data_q;
          end
        end
      end
      WR_WAIT: begin
        if (wr_done) begin
          rsp_timeout_nxt = 1'b0;
          rsp_valid_nxt   = 1'b1;
          state_nxt       = RESP;
        end
      end
      RESP: begin
        if (RSP_READY) begin
          rsp_valid_nxt   = 1'b0;
          rsp_timeout_nxt = 1'b0;
          state_nxt       = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state       <= IDLE;
      run_q       <= 1'b0;
      op_q        <= OP_WRITE;
      data_q      <= '0;
      mask_q      <= '0;
      tmr         <= '0;
      RSP_VALID   <= 1'b0;
      RSP_TIMEOUT <= 1'b0;
      RSP_DATA    <= '0;
      AMCI_WADDR  <= '0;
      AMCI_WDATA  <= '0;
      AMCI_RADDR  <= '0;
      AMCI_WRITE  <= 1'b0;
      AMCI_READ   <= 1'b0;
    end else begin
      state       <= state_nxt;
      run_q       <= 1'b1;
      op_q        <= op_nxt;
      data_q      <= data_nxt;
      mask_q      <= mask_nxt;
      tmr         <= tmr_nxt;
      RSP_VALID   <= rsp_valid_nxt;
      RSP_TIMEOUT <= rsp_timeout_nxt;
      RSP_DATA    <= rsp_data_nxt;
      AMCI_WADDR  <= waddr_nxt;
      AMCI_WDATA  <= wdata_nxt;
      AMCI_RADDR  <= raddr_nxt;
      AMCI_WRITE  <= write_nxt;
      AMCI_READ   <= read_nxt;
    end
  end

endmodule

// File: tb/tb_amci_cmd_sequencer.sv
// Directed bench for amci_cmd_sequencer with a behavioural AMCI master/slave and
// a response model derived from the command rules.
module tb_amci_cmd_sequencer;
  import amci_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int PT  = 20;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          CMD_VALID = 1'b0, CMD_READY;
  logic [1:0]    CMD_OP = 2'd0;
  logic [AW-1:0] CMD_ADDR = '0;
  logic [DW-1:0] CMD_DATA = '0, CMD_MASK = '0;
  logic          RSP_VALID, RSP_READY = 1'b0, RSP_TIMEOUT;
  logic [DW-1:0] RSP_DATA;
  logic [AW-1:0] AMCI_WADDR, AMCI_RADDR;
  logic [DW-1:0] AMCI_WDATA, AMCI_RDATA = '0;
  logic          AMCI_WRITE, AMCI_READ, AMCI_WIDLE = 1'b1, AMCI_RIDLE = 1'b1;

  always #5 clk = ~clk;

  amci_cmd_sequencer #(
    .C_AXI_DATA_WIDTH(DW), .C_AXI_ADDR_WIDTH(AW), .POLL_TIMEOUT(PT)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP),
    .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA), .CMD_MASK(CMD_MASK),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA),
    .RSP_TIMEOUT(RSP_TIMEOUT),
    .AMCI_WADDR(AMCI_WADDR), .AMCI_WDATA(AMCI_WDATA), .AMCI_WRITE(AMCI_WRITE),
    .AMCI_WIDLE(AMCI_WIDLE), .AMCI_RADDR(AMCI_RADDR), .AMCI_READ(AMCI_READ),
    .AMCI_RDATA(AMCI_RDATA), .AMCI_RIDLE(AMCI_RIDLE)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // slave register file, poll data script and per-command bookkeeping
  logic [31:0] mem [logic [31:0]];
  logic [31:0] poll_q [$];
  logic [1:0]  cur_op;
  logic [31:0] cur_addr, cur_data, cur_mask;
  int          nc = 0, acc_nc = 0;
  bit          outstanding = 0, armed = 0, wstall = 0;
  int          rbusy = 0, wbusy = 0;
  int          rd_cnt = 0, wr_cnt = 0, rd_done_cnt = 0, rsp_seen = 0;
  int          last_rd_nc = 0, first_wr_nc = 0;
  bit          prev_read = 0, prev_write = 0;
  logic [31:0] wr_addr_seen = '0, wr_data_seen = '0, last_rsp_data = '0;
  logic        last_rsp_to = 1'b0;
  bit          exp_known = 0;
  logic [31:0] exp_data = '0;
  logic        exp_to = 1'b0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      outstanding = 0;
      armed = 0;
    end else begin
      armed = 1;
      if (CMD_VALID && CMD_READY) begin
        outstanding = 1;
        acc_nc = nc + 1;
      end
      if (RSP_VALID && RSP_READY) outstanding = 0;
    end
  end

  // compare process and AMCI master model; checks use values from before this edge's updates
  always @(negedge clk) begin
    logic ridle0, widle0;
    int rb0, wb0, n;
    logic [31:0] rd;
    nc++;
    ridle0 = AMCI_RIDLE; widle0 = AMCI_WIDLE; rb0 = rbusy; wb0 = wbusy;
    if (!rst_n) begin
      rbusy = 0; wbusy = 0; AMCI_RIDLE = 1'b1; AMCI_WIDLE = !wstall;
      prev_read = 0; prev_write = 0;
    end else begin
      chk("cmd_ready", CMD_READY, armed && !outstanding);
      if (RSP_VALID) begin
        rsp_seen++;
        chk("rsp_expected_yet", exp_known, 1);
        chk("rsp_data", RSP_DATA, exp_data);
        chk("rsp_timeout", RSP_TIMEOUT, exp_to);
        last_rsp_data = RSP_DATA; last_rsp_to = RSP_TIMEOUT;
      end
      if (AMCI_WRITE) begin
        wr_cnt++;
        if (wr_cnt == 1) first_wr_nc = nc;
        chk("write_pulse_width", prev_write, 0);
        chk("write_when_idle", widle0 && rb0 == 0, 1);
        chk("waddr", AMCI_WADDR, cur_addr);
        wr_addr_seen = AMCI_WADDR; wr_data_seen = AMCI_WDATA;
        mem[AMCI_WADDR] = AMCI_WDATA;
        wbusy = LAT;
      end else if (wbusy > 0) wbusy--;
      if (AMCI_READ) begin
        rd_cnt++;
        last_rd_nc = nc;
        chk("read_not_with_write", AMCI_WRITE, 0);
        chk("read_pulse_width", prev_read, 0);
        chk("read_when_idle", ridle0 && wb0 == 0, 1);
        chk("raddr", AMCI_RADDR, cur_addr);
        rbusy = LAT; AMCI_RIDLE = 1'b0;
      end else if (rbusy > 0) begin
        rbusy--;
        if (rbusy == 0) begin
          if (poll_q.size() > 0) rd = poll_q.pop_front();
          else rd = mem_rd(cur_addr);
          AMCI_RDATA = rd; AMCI_RIDLE = 1'b1;
          rd_done_cnt++;
          // POLL outcome: match wins, otherwise expiry once PT cycles have elapsed
          if (cur_op == OP_POLL) begin
            n = nc - acc_nc;
            if ((rd & cur_mask) == (cur_data & cur_mask)) begin
              exp_data = rd; exp_to = 1'b0; exp_known = 1;
            end else if (PT != 0 && n >= PT) begin
              exp_data = rd; exp_to = 1'b1; exp_known = 1;
            end
          end
        end
      end
      AMCI_WIDLE = (wbusy == 0) && !wstall;
      prev_read = AMCI_READ; prev_write = AMCI_WRITE;
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, d, m);
    int k;
    cur_op = op; cur_addr = a; cur_data = d; cur_mask = m;
    rd_cnt = 0; wr_cnt = 0; rd_done_cnt = 0; rsp_seen = 0;
    first_wr_nc = 0; last_rd_nc = 0;
    @(negedge clk); #1;
    CMD_VALID = 1'b1; CMD_OP = op; CMD_ADDR = a; CMD_DATA = d; CMD_MASK = m;
    k = 0;
    while (!outstanding && k < 50) begin @(negedge clk); k++; end
    chk("accept_in_time", outstanding, 1);
    #1;
    // scramble the command bus; the DUT must have latched at acceptance
    CMD_VALID = 1'b0; CMD_OP = ~op; CMD_ADDR = a ^ 32'hFF; CMD_DATA = ~d; CMD_MASK = ~m;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [31:0] a, d, m, input int hold);
    logic [31:0] old, wd;
    int nr, nw, k;
    old = mem_rd(a);
    wd = '0; nr = 0; nw = 0;
    exp_known = 1; exp_to = 1'b0;
    case (op)
      OP_WRITE: begin exp_data = d; nw = 1; wd = d; end
      OP_READ:  begin exp_data = old; nr = 1; end
      OP_RMW:   begin exp_data = old; nr = 1; nw = 1; wd = (old & ~m) | (d & m); end
      default:  exp_known = 0;
    endcase
    issue(op, a, d, m);
    k = 0;
    while (!RSP_VALID && k < 500) begin @(negedge clk); k++; end
    chk("rsp_in_time", RSP_VALID, 1);
    repeat (hold) @(negedge clk);
    chk("rsp_held", RSP_VALID, 1);
    #1 RSP_READY = 1'b1;
    @(negedge clk); #1 RSP_READY = 1'b0;
    chk("rsp_cleared", RSP_VALID, 0);
    if (op == OP_POLL) nr = rd_done_cnt;
    chk("read_count", rd_cnt, nr);
    chk("write_count", wr_cnt, nw);
    if (nw > 0) begin
      chk("write_addr", wr_addr_seen, a);
      chk("write_data", wr_data_seen, wd);
    end
    if (op == OP_RMW) chk("rmw_read_before_write", first_wr_nc > last_rd_nc, 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_cmd_ready"}, CMD_READY, 0);
    chk({tag, "_rsp_valid"}, RSP_VALID, 0);
    chk({tag, "_rsp_timeout"}, RSP_TIMEOUT, 0);
    chk({tag, "_rsp_data"}, RSP_DATA, 0);
    chk({tag, "_write"}, AMCI_WRITE, 0);
    chk({tag, "_read"}, AMCI_READ, 0);
    chk({tag, "_waddr"}, AMCI_WADDR, 0);
    chk({tag, "_wdata"}, AMCI_WDATA, 0);
    chk({tag, "_raddr"}, AMCI_RADDR, 0);
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_cmd(OP_WRITE, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    chk("lit_write_data", wr_data_seen, 32'hDEADBEEF);
    chk("lit_write_rsp", last_rsp_data, 32'hDEADBEEF);

    mem[32'h20] = 32'h12345678;
    run_cmd(OP_READ, 32'h20, 32'h0, 32'h0, 10);
    chk("lit_read_rsp", last_rsp_data, 32'h12345678);

    mem[32'h30] = 32'hAAAA5555;
    run_cmd(OP_RMW, 32'h30, 32'h00001200, 32'h0000FF00, 3);
    chk("lit_rmw_write", wr_data_seen, 32'hAAAA1255);
    chk("lit_rmw_rsp", last_rsp_data, 32'hAAAA5555);

    poll_q = '{32'h0, 32'h0, 32'h0, 32'h1};
    run_cmd(OP_POLL, 32'h40, 32'h1, 32'h1, 0);
    chk("lit_poll_reads", rd_cnt, 4);
    chk("lit_poll_rsp", last_rsp_data, 32'h1);
    chk("lit_poll_to", last_rsp_to, 0);

    // reads complete 2,5,8,...,20 cycles after acceptance; the 7th is the first at/after 20
    run_cmd(OP_POLL, 32'h44, 32'h1, 32'h1, 2);
    chk("lit_poll_timeout_reads", rd_cnt, 7);
    chk("lit_poll_timeout_flag", last_rsp_to, 1);
    chk("lit_poll_timeout_data", last_rsp_data, 32'h0);

    poll_q = '{32'h5};
    run_cmd(OP_POLL, 32'h48, 32'hFFFFFFFF, 32'h0, 0);
    chk("lit_poll_mask0_reads", rd_cnt, 1);

    mem[32'h60] = 32'hCAFEF00D;
    run_cmd(OP_RMW, 32'h60, 32'hFFFFFFFF, 32'h0, 0);
    chk("lit_rmw_mask0_write", wr_data_seen, 32'hCAFEF00D);

    // reset between the RMW read and its write
    mem[32'h50] = 32'h00001111;
    exp_known = 0;
    issue(OP_RMW, 32'h50, 32'h2, 32'hF);
    k = 0;
    while (rd_cnt < 1 && k < 50) begin @(negedge clk); k++; end
    chk("rst_test_read_seen", rd_cnt, 1);
    #1 wstall = 1;
    repeat (4) @(negedge clk);
    chk("rst_test_write_held_off", wr_cnt, 0);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1; wstall = 0;
    repeat (20) @(negedge clk);
    chk("post_reset_no_write", wr_cnt, 0);
    chk("post_reset_no_rsp", rsp_seen, 0);
    chk("post_reset_ready", CMD_READY, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=not_finished required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
